// File: rtl/mem_sram_ctrl_if.sv
// mem_sram_ctrl_if
//   Bundles the MEM-stage pipeline side and the external 16-bit SRAM side of
//   the data-memory controller.
//   slave  : the controller (mem_sram_ctrl).
//   master : its environment, meaning the EXE->MEM register, the MEM->WB
//            register and the SRAM data bus. The SRAM read data therefore
//            originates on the master side.
//   Signals:
//     rd_en, wr_en        load / store request
//     address             32-bit byte address
//     write_data          32-bit store data
//     read_data           32-bit load result
//     ready               0 = freeze the pipeline
//     sram_addr           SRAM half-word address
//     sram_dq_o/_i/_oe    SRAM data out / data in / output enable
//     sram_we_n           SRAM write enable, active-low
interface mem_sram_ctrl_if #(
    parameter int unsigned SRAM_AW = 18
);
    logic               rd_en;
    logic               wr_en;
    logic [31:0]        address;
    logic [31:0]        write_data;
    logic [31:0]        read_data;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_o;
    logic [15:0]        sram_dq_i;
    logic               sram_dq_oe;
    logic               sram_we_n;

    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_i,
        input  read_data, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_i,
        output read_data, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl
//   MEM-stage data-memory controller. Turns one 32-bit load/store from the
//   EXE->MEM register into two 16-bit accesses (low half, then high half) on
//   an external SRAM, holding 'ready' low until the access finishes.
//   Ports:
//     clk   clock, rising edge
//     rst   synchronous reset, active-high
//     bus   mem_sram_ctrl_if.slave: pipeline request/response plus SRAM pins
//   Parameters:
//     ADDR_BASE  byte address mapped to SRAM word 0
//     SRAM_AW    SRAM half-word address width
//     WAIT_CYC   extra wait cycles per half-word phase
module mem_sram_ctrl #(
    parameter logic [31:0] ADDR_BASE = 32'd1024,
    parameter int unsigned SRAM_AW   = 18,
    parameter int unsigned WAIT_CYC  = 1
) (
    input  logic           clk,
    input  logic           rst,
    mem_sram_ctrl_if.slave bus
);

    localparam int unsigned    CW       = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WAIT_CYC);
    localparam int unsigned    WW       = SRAM_AW - 1;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    // Request captured on the IDLE->LO edge
    logic               op_wr_q;
    logic [WW-1:0]      word_q;
    logic [31:0]        data_q;

    logic [31:0]        offset;
    logic               req;
    logic               phase_last;
    logic               latch;

    logic               eff_wr;
    logic [WW-1:0]      eff_word;
    logic [31:0]        eff_data;

    logic [SRAM_AW-1:0] sram_addr_d, sram_addr_q;
    logic [15:0]        sram_dq_o_d, sram_dq_o_q;
    logic               sram_we_n_d, sram_we_n_q;
    logic               sram_dq_oe_d, sram_dq_oe_q;
    logic [31:0]        read_data_q;

    // Only the word index of the offset is meaningful; the byte lane bits
    // and the bits above the SRAM range are deliberately ignored.
    logic               unused_offset_bits;

    assign offset     = bus.address - ADDR_BASE;
    assign req        = bus.rd_en | bus.wr_en;
    assign phase_last = (cnt_q == CNT_LAST);
    assign latch      = (state_q == IDLE) && req;

    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    // Next state and phase counter; the counter clears on every state change
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LO;
                end
            end
            LO: begin
                if (phase_last) begin
                    state_d = HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HI: begin
                if (phase_last) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The SRAM pins are registered from the next state, so the first LO cycle
    // must already see the request; on the latch edge the live inputs are
    // used, afterwards the captured copy.
    always_comb begin
        eff_wr   = latch ? bus.wr_en : op_wr_q;
        eff_word = latch ? offset[SRAM_AW:2] : word_q;
        eff_data = latch ? bus.write_data : data_q;

        sram_addr_d  = '0;
        sram_dq_o_d  = '0;
        sram_we_n_d  = 1'b1;
        sram_dq_oe_d = 1'b0;
        case (state_d)
            LO: begin
                sram_addr_d = {eff_word, 1'b0};
                if (eff_wr) begin
                    sram_we_n_d  = 1'b0;
                    sram_dq_oe_d = 1'b1;
                    sram_dq_o_d  = eff_data[15:0];
                end
            end
            HI: begin
                sram_addr_d = {eff_word, 1'b1};
                if (eff_wr) begin
                    sram_we_n_d  = 1'b0;
                    sram_dq_oe_d = 1'b1;
                    sram_dq_o_d  = eff_data[31:16];
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_wr_q      <= 1'b0;
            word_q       <= '0;
            data_q       <= '0;
            sram_addr_q  <= '0;
            sram_dq_o_q  <= '0;
            sram_we_n_q  <= 1'b1;
            sram_dq_oe_q <= 1'b0;
            read_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sram_addr_q  <= sram_addr_d;
            sram_dq_o_q  <= sram_dq_o_d;
            sram_we_n_q  <= sram_we_n_d;
            sram_dq_oe_q <= sram_dq_oe_d;

            // A simultaneous rd_en/wr_en is treated as a store
            if (latch) begin
                op_wr_q <= bus.wr_en;
                word_q  <= offset[SRAM_AW:2];
                data_q  <= bus.write_data;
            end

            // Read data is sampled at the end of each phase's last cycle
            if (!op_wr_q && phase_last) begin
                if (state_q == LO) begin
                    read_data_q[15:0] <= bus.sram_dq_i;
                end
                if (state_q == HI) begin
                    read_data_q[31:16] <= bus.sram_dq_i;
                end
            end
        end
    end

    assign bus.ready      = ((state_q == IDLE) && !req) || (state_q == DONE);
    assign bus.read_data  = read_data_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_dq_o  = sram_dq_o_q;
    assign bus.sram_we_n  = sram_we_n_q;
    assign bus.sram_dq_oe = sram_dq_oe_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl
//   Self-checking bench for mem_sram_ctrl: directed scenarios followed by a
//   randomized load/store sequence, compared against a word-level memory
//   reference and an SRAM model that needs a full phase of write pulse.
module tb_mem_sram_ctrl;

    localparam int unsigned W    = 1;
    localparam int unsigned AW   = 18;
    localparam int unsigned PH   = W + 1;
    localparam int unsigned NHW  = 1 << AW;
    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_sram_ctrl_if #(.SRAM_AW(AW)) bus ();

    mem_sram_ctrl #(
        .ADDR_BASE (BASE),
        .SRAM_AW   (AW),
        .WAIT_CYC  (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // ---------------- SRAM model ----------------
    // A half-word is committed only once we_n has been held low on the same
    // address for a whole phase, so an access cut short by reset leaves that
    // half-word untouched.
    logic [15:0]   sram_mem [0:NHW-1];
    bit            mem_init_done = 1'b0;
    bit            prev_we_low   = 1'b0;
    logic [AW-1:0] prev_addr     = '0;
    int unsigned   wr_hold       = 0;
    int unsigned   wr_run;

    function automatic logic [15:0] hw_init(input int unsigned i);
        return 16'((i * 32'd40503) ^ 32'h0000_5A5A);
    endfunction

    assign bus.sram_dq_i = sram_mem[bus.sram_addr];
    assign wr_run = (prev_we_low && (bus.sram_addr == prev_addr)) ? wr_hold + 1 : 1;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < NHW; i++) sram_mem[i] <= hw_init(i);
            mem_init_done <= 1'b1;
        end else if (bus.sram_we_n == 1'b0) begin
            wr_hold <= wr_run;
            if (wr_run == PH) sram_mem[bus.sram_addr] <= bus.sram_dq_o;
        end else begin
            wr_hold <= 0;
        end
        prev_we_low <= (bus.sram_we_n == 1'b0);
        prev_addr   <= bus.sram_addr;
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [0:NHW-1];
    logic [31:0] ref_rd = '0;

    function automatic int unsigned word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off >> 2) % (1 << (AW - 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int unsigned n);
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(bus.ready), 32'd1);
            check("idle_we_n", 32'(bus.sram_we_n), 32'd1);
            check("idle_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    // Runs one access from request to the pipeline-advance edge. Called at
    // #1 after a rising edge; returns at #1 after the edge that leaves DONE,
    // with the request dropped, so back-to-back calls add no bubble.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit scramble);
        int unsigned w;
        int unsigned frozen;
        int unsigned half;
        bit          is_wr;
        w      = word_of(addr);
        is_wr  = wr;
        frozen = 0;
        bus.rd_en      = rd;
        bus.wr_en      = wr;
        bus.address    = addr;
        bus.write_data = wdata;
        while (frozen < 40) begin
            @(negedge clk);
            if (bus.ready) break;
            if (frozen == 0) begin
                check("req_we_n", 32'(bus.sram_we_n), 32'd1);
                check("req_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
            end else if (frozen <= 2 * PH) begin
                half = (frozen > PH) ? 1 : 0;
                check("sram_addr", 32'(bus.sram_addr), 2 * w + half);
                check("sram_we_n", 32'(bus.sram_we_n), is_wr ? 32'd0 : 32'd1);
                check("sram_dq_oe", 32'(bus.sram_dq_oe), is_wr ? 32'd1 : 32'd0);
                if (is_wr)
                    check("sram_dq_o", 32'(bus.sram_dq_o),
                          half != 0 ? 32'(wdata[31:16]) : 32'(wdata[15:0]));
            end
            frozen++;
            @(posedge clk); #1;
            if (scramble) begin
                bus.address    = $urandom;
                bus.write_data = $urandom;
            end
        end
        check("freeze_len", frozen, 2 * PH + 1);

        if (is_wr) begin
            ref_mem[2 * w]     = wdata[15:0];
            ref_mem[2 * w + 1] = wdata[31:16];
            check("sram_lo_half", 32'(sram_mem[2 * w]), 32'(ref_mem[2 * w]));
            check("sram_hi_half", 32'(sram_mem[2 * w + 1]), 32'(ref_mem[2 * w + 1]));
        end else begin
            ref_rd = {ref_mem[2 * w + 1], ref_mem[2 * w]};
        end
        check("read_data", bus.read_data, ref_rd);
        check("done_we_n", 32'(bus.sram_we_n), 32'd1);
        check("done_dq_oe", 32'(bus.sram_dq_oe), 32'd0);

        @(posedge clk); #1;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int unsigned op;

        for (int i = 0; i < NHW; i++) ref_mem[i] = hw_init(i);

        rst            = 1'b1;
        bus.rd_en      = 1'b0;
        bus.wr_en      = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_we_n", 32'(bus.sram_we_n), 32'd1);
        check("rst_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
        check("rst_sram_addr", 32'(bus.sram_addr), 32'd0);
        check("rst_dq_o", 32'(bus.sram_dq_o), 32'd0);
        check("rst_read_data", bus.read_data, 32'd0);
        @(posedge clk); #1;

        // Idle for 10 cycles
        idle_cycles(10);

        // Store 0xDEADBEEF at 1032 -> SRAM 4/5
        access(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 1'b0);
        idle_cycles(1);
        check("t2_sram4", 32'(sram_mem[4]), 32'h0000_BEEF);
        check("t2_sram5", 32'(sram_mem[5]), 32'h0000_DEAD);

        // Load it back, then a store must leave read_data alone
        access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b1);
        check("t3_load", bus.read_data, 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 32'd1036, 32'h0BAD_F00D, 1'b1);
        check("t3_keep", bus.read_data, 32'hDEAD_BEEF);
        idle_cycles(2);

        // Back-to-back: load at 1024 then store at 1028, no bubble
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
        access(1'b0, 1'b1, 32'd1028, 32'hA5A5_5A5A, 1'b0);
        idle_cycles(1);

        // rd_en and wr_en together act as a store
        access(1'b1, 1'b1, 32'd1040, 32'h1234_5678, 1'b0);
        check("t6_sram8", 32'(sram_mem[8]), 32'h0000_5678);
        check("t6_sram9", 32'(sram_mem[9]), 32'h0000_1234);
        check("t6_rd_keep", bus.read_data, ref_rd);
        idle_cycles(1);

        // Reset during the first HI cycle of a store at 1032
        bus.wr_en      = 1'b1;
        bus.address    = 32'd1032;
        bus.write_data = 32'hCAFE_F00D;
        repeat (1 + PH) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("t5_in_hi", 32'(bus.sram_addr), 32'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.wr_en = 1'b0;
        @(negedge clk);
        ref_mem[4] = 16'hF00D;
        ref_rd     = '0;
        check("t5_ready", 32'(bus.ready), 32'd1);
        check("t5_we_n", 32'(bus.sram_we_n), 32'd1);
        check("t5_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
        check("t5_read_data", bus.read_data, 32'd0);
        check("t5_sram4", 32'(sram_mem[4]), 32'(ref_mem[4]));
        check("t5_sram5", 32'(sram_mem[5]), 32'(ref_mem[5]));
        @(posedge clk); #1;

        // Randomized traffic
        for (int unsigned n = 0; n < 40; n++) begin
            op = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = BASE + 32'($urandom_range(0, 63));
            d = $urandom;
            access(op != 1, op != 0, a, d, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
